// File: rtl/soc_system_button_pkg.sv
// Shared constants and types for the push-button event controller.
// Covers the register map, the CTRL fields, the edge modes and the debounce state type.
package soc_system_button_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_MODE_LSB   = 1;
    localparam int CTRL_MODE_MSB   = 2;

    localparam logic [1:0] MODE_FALL = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    typedef enum logic {
        DB_STABLE,
        DB_COUNT
    } db_state_t;

    // Encoding 11 behaves like MODE_BOTH.
    function automatic logic edge_selected(input logic [1:0] mode, input logic rise, input logic fall);
        case (mode)
            MODE_FALL: edge_selected = fall;
            MODE_RISE: edge_selected = rise;
            default:   edge_selected = rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/soc_system_button_debounce.sv
// One-bit button conditioner: a 2-FF synchroniser followed by a debounce FSM.
// Produces the accepted level and single-clock rise/fall pulses that coincide with the level flip.
module soc_system_button_debounce
    import soc_system_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_level;
    logic          stable;
    logic          stable_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    db_state_t     state;
    db_state_t     state_next;

    // Buttons are active-low, so the idle level is 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta  <= 1'b1;
            sync_level <= 1'b1;
        end else begin
            sync_meta  <= raw;
            sync_level <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= DB_STABLE;
            count  <= '0;
            stable <= 1'b1;
        end else begin
            state  <= state_next;
            count  <= count_next;
            stable <= stable_next;
        end
    end

    // The counter stops at CNT_LAST, which is also where the flip is taken, so it cannot wrap.
    always_comb begin
        state_next  = state;
        count_next  = count;
        stable_next = stable;
        rise        = 1'b0;
        fall        = 1'b0;
        case (state)
            DB_STABLE: begin
                if (sync_level != stable) begin
                    state_next = DB_COUNT;
                    count_next = '0;
                end
            end
            DB_COUNT: begin
                if (sync_level == stable) begin
                    state_next = DB_STABLE;
                end else if (count == CNT_LAST) begin
                    stable_next = ~stable;
                    state_next  = DB_STABLE;
                    rise        = ~stable;
                    fall        = stable;
                end else begin
                    count_next = count + CW'(1);
                end
            end
        endcase
    end

    assign level = stable;

endmodule

// File: rtl/soc_system_button_event_ctrl.sv
// Avalon-MM push-button controller: debounced levels, sticky edge capture and a maskable interrupt.
// The interface has no waitrequest, and readdata is registered one clock after the read strobe.
module soc_system_button_event_ctrl
    import soc_system_button_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] events;
    logic [WIDTH-1:0] wr_clear;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_cap;
    logic [2:0]       ctrl;
    logic [31:0]      read_word;
    logic             wr_en;
    logic             rd_en;
    logic             unused_writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_btn
        soc_system_button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (in_port[i]),
            .level  (level[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign wr_en            = chipselect & write;
    assign rd_en            = chipselect & read;
    assign unused_writedata = &{1'b0, writedata};

    always_comb begin
        events   = '0;
        wr_clear = '0;
        for (int i = 0; i < WIDTH; i++) begin
            events[i] = ctrl[CTRL_ENABLE_BIT] &
                        edge_selected(ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB], rise[i], fall[i]);
        end
        if (wr_en && address == REG_EDGE) begin
            wr_clear = writedata[WIDTH-1:0];
        end
    end

    // A new event is ORed in after the W1C clear, so a simultaneous set wins on that bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask     <= '0;
            ctrl     <= 3'b001;
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && address == REG_MASK) mask <= writedata[WIDTH-1:0];
            if (wr_en && address == REG_CTRL) ctrl <= writedata[2:0];
            edge_cap <= (edge_cap & ~wr_clear) | events;
            irq      <= |(edge_cap & mask);
        end
    end

    always_comb begin
        read_word = '0;
        case (address)
            REG_DATA: read_word[WIDTH-1:0] = level;
            REG_MASK: read_word[WIDTH-1:0] = mask;
            REG_EDGE: read_word[WIDTH-1:0] = edge_cap;
            REG_CTRL: read_word[2:0]       = ctrl;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= read_word;
        end
    end

endmodule

// File: doc/soc_system_button_event_ctrl.md
# soc_system_button_event_ctrl

Avalon-MM controller for the push-button inputs. It synchronises and debounces each button, detects configurable edges, latches them in a sticky capture register, and raises a maskable level interrupt to the Nios II. It replaces the bare read-only button port in `soc_system` and gives software event-driven access instead of polling.

## Interface
Parameters:
- `WIDTH`, 3: number of button inputs (1..32).
- `DEBOUNCE_CYCLES`, 50000: consecutive stable samples required to accept a level change (≥2); 1 ms at 50 MHz.

Ports:
- `clk`: input, 1, system clock.
- `reset_n`: input, 1, asynchronous active-low reset.
- `address`: input, 2, register word offset.
- `chipselect`: input, 1, slave select.
- `read`: input, 1, read strobe.
- `write`: input, 1, write strobe.
- `writedata`: input, 32, write data.
- `readdata`: output, 32, registered read data.
- `in_port`: input, WIDTH, raw asynchronous button levels (active-low; released = 1).
- `irq`: output, 1, registered level interrupt.

## Operation
- Register map (word offsets):
  - 0 `DATA` (RO): debounced levels, zero-extended.
  - 1 `MASK` (RW): per-bit IRQ enable.
  - 2 `EDGE` (RW1C): sticky edge capture; writing 1 clears the bit, writing 0 leaves it unchanged.
  - 3 `CTRL` (RW): bit0 `enable`; bits[2:1] `mode` (00 falling, 01 rising, 10/11 both edges).
- Writes to `DATA` are ignored. Unimplemented bits read 0. Reads have no side effects.
- Input path: 2-FF synchroniser per bit, then a per-bit debounce FSM with a shared-width counter, `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - `STABLE`: if sync ≠ stable value, clear the counter and go to `COUNT`.
  - `COUNT`: while sync ≠ stable, increment. If sync returns to the stable value, go to `STABLE` with no update. When the counter reaches `DEBOUNCE_CYCLES-1` and sync still differs, invert the stable value and go to `STABLE`. The counter saturates and never wraps.
- Edge event: the stable value flips in the direction selected by `mode`. `EDGE[i]` is set on the same clock as the flip, only if `enable` = 1.
- Clearing `enable` stops new captures; existing `EDGE` bits are retained.
- Simultaneous W1C and new edge on the same bit: the set wins. Other bits clear normally.
- `irq` = registered `|(EDGE & MASK)`. Writing `MASK` updates `irq` on the following clock.
- Reset values:
  - `readdata` 0, `irq` 0, `MASK` 0, `EDGE` 0.
  - `CTRL` = 001b (enabled, falling edge).
  - Synchroniser and stable values all ones; FSMs in `STABLE`; counters 0.
- Reset mid-debounce aborts the count. No edge is reported for the aborted transition.

## Timing
- Read latency is 1 clock: `readdata` is registered on the clock where `chipselect & read`. Otherwise `readdata` holds its last value. No waitrequest.
- Writes take effect on the clock edge where `chipselect & write`. A read of the same register on the next cycle returns the new value.
- For a clean `in_port` step held steady:
  - `DATA`/`EDGE` update `DEBOUNCE_CYCLES+2` clocks after the first sampling edge.
  - `irq` asserts 1 clock later, if masked in.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised samples produce no `DATA` change and no event.

## Structure
- Package `soc_system_button_pkg`:
  - Register offset constants `REG_DATA`/`REG_MASK`/`REG_EDGE`/`REG_CTRL`.
  - `CTRL` bit positions.
  - Edge-mode encodings `MODE_FALL`/`MODE_RISE`/`MODE_BOTH`.
  - Debounce FSM state typedef.
- Sub-module `soc_system_button_debounce`: one bit, containing the synchroniser, FSM and counter. Outputs the stable level and a one-clock `rise`/`fall` pulse. Instantiated `WIDTH` times.
- The top level holds the register file, capture logic, IRQ and read mux.

## Test plan (`DEBOUNCE_CYCLES`=4, `WIDTH`=3)
- Reset, read all four registers → `DATA`=0x7, `MASK`=0, `EDGE`=0, `CTRL`=0x1; `irq`=0.
- Drive `in_port[1]` 1→0 and hold → `EDGE`=0x2 exactly 6 clocks after the change is sampled. `irq` stays 0; write `MASK`=0x2 → `irq`=1 the next clock.
- 3-clock low glitch on `in_port[0]` → `DATA` stays 0x7, `EDGE` stays 0.
- `EDGE`=0x2, write `EDGE`=0x2 on the same clock bit1 gets a new debounced falling edge → `EDGE` stays 0x2, `irq` stays 1.
- `CTRL`=0x5 (both edges), press then release `in_port[2]` → `EDGE[2]` set on each transition. Clear between them → two distinct events.
- `reset_n` asserted mid-debounce (counter=2), released with input held low → `DATA` reads 0x7 after reset. Then the debounce runs a full 4 samples before `DATA[bit]`=0.
